// File: rtl/dmem_store_unit_pkg.sv
// Shared RV32I store-path types: store width encodings and the store FSM state.
package dmem_store_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NLANE = 4;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } store_state_t;

endpackage

// File: rtl/dmem_store_unit_store_align.sv
// Combinational lane placement for RV32I stores: builds the byte mask and
// lane-shifted data, and flags misaligned or illegal store widths.
module store_align
    import dmem_store_unit_pkg::*;
(
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_off,
    input  logic [XLEN-1:0]  rs2_data,
    output logic [NLANE-1:0] wmask,
    output logic [XLEN-1:0]  wdata,
    output logic             misaligned
);

    always_comb begin
        wmask      = '0;
        wdata      = '0;
        misaligned = 1'b0;
        case (funct3)
            SB: begin
                // Source byte is isolated first so unmasked lanes stay zero.
                wmask = 4'b0001 << addr_off;
                wdata = {24'b0, rs2_data[7:0]} << {addr_off, 3'b000};
            end
            SH: begin
                if (addr_off[0]) begin
                    misaligned = 1'b1;
                end else begin
                    wmask = addr_off[1] ? 4'b1100 : 4'b0011;
                    wdata = {16'b0, rs2_data[15:0]} << {addr_off[1], 4'b0000};
                end
            end
            SW: begin
                if (addr_off != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    wmask = 4'b1111;
                    wdata = rs2_data;
                end
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_store_unit.sv
// MEM-stage store unit: aligns the store, issues one data-memory write and
// stalls the pipeline until the memory responds.
module dmem_store_unit
    import dmem_store_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              flush,
    input  logic              dmem_resp,
    output logic [XLEN-1:0]   dmem_address,
    output logic              dmem_write,
    output logic [NLANE-1:0]  dmem_wmask,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic              stall,
    output logic              store_done,
    output logic              misalign_err,
    output store_state_t      dbg_state
);

    // Handshake: dmem_write rises the cycle after a store is accepted and
    // holds, with address/mask/data stable, until the cycle dmem_resp is high;
    // that cycle completes the write and dmem_write drops at the next edge.
    // dmem_resp outside an outstanding write carries no meaning and is ignored.

    store_state_t     state;
    logic [NLANE-1:0] al_wmask;
    logic [XLEN-1:0]  al_wdata;
    logic             al_misaligned;
    logic             req_live;
    logic             accept;

    store_align u_align (
        .funct3     (funct3),
        .addr_off   (addr[1:0]),
        .rs2_data   (rs2_data),
        .wmask      (al_wmask),
        .wdata      (al_wdata),
        .misaligned (al_misaligned)
    );

    assign req_live = (state == IDLE) && req_valid && !flush;
    assign accept   = req_live && !al_misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            dmem_write   <= 1'b0;
            dmem_address <= '0;
            dmem_wmask   <= '0;
            dmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= BUSY;
                        dmem_write   <= 1'b1;
                        dmem_address <= {addr[XLEN-1:2], 2'b00};
                        dmem_wmask   <= al_wmask;
                        dmem_wdata   <= al_wdata;
                    end
                end
                BUSY: begin
                    // Flush is deliberately not looked at: an issued write must finish.
                    if (dmem_resp) begin
                        state      <= IDLE;
                        dmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dmem_write <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are gated by reset so every output sits at zero while held in reset.
    assign store_done   = rst && (state == BUSY) && dmem_resp;
    assign misalign_err = rst && req_live && al_misaligned;
    assign stall        = rst && (((state == BUSY) && !dmem_resp) || accept);
    assign dbg_state    = state;

endmodule
